// File: rtl/mc_controlunit_pkg.sv
// mc_defs: shared state, opcode/funct and mux-select encodings for the multi-cycle control unit.
package mc_defs;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTYPE_EX, S_ALU_WB,
        S_ADDI_EX, S_IMM_WB, S_BRANCH, S_JUMP, S_JAL, S_JR, S_MD_BUSY, S_MFHILO
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_AND    = 6'b100100;
    localparam logic [5:0] F_OR     = 6'b100101;
    localparam logic [5:0] F_SLT    = 6'b101010;
    localparam logic [5:0] F_MULTU  = 6'b011001;
    localparam logic [5:0] F_DIVU   = 6'b011011;
    localparam logic [5:0] F_MFHI   = 6'b010000;
    localparam logic [5:0] F_MFLO   = 6'b010010;
    localparam logic [5:0] F_JR     = 6'b001000;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    localparam logic [1:0] PC_ALU   = 2'b00;
    localparam logic [1:0] PC_BR    = 2'b01;
    localparam logic [1:0] PC_JMP   = 2'b10;
    localparam logic [1:0] PC_RS    = 2'b11;
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MDR   = 2'b01;
    localparam logic [1:0] WB_PC    = 2'b10;
    localparam logic [1:0] WB_HILO  = 2'b11;
    localparam logic [1:0] SRCB_RT  = 2'b00;
    localparam logic [1:0] SRCB_4   = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;
    localparam logic [1:0] RD_RT    = 2'b00;
    localparam logic [1:0] RD_RD    = 2'b01;
    localparam logic [1:0] RD_RA    = 2'b10;

    function automatic logic is_alu_funct(input logic [5:0] f);
        return f == F_ADD || f == F_SUB || f == F_AND || f == F_OR || f == F_SLT;
    endfunction
endpackage

// File: rtl/mc_controlunit_aludec.sv
// mc_aludec: R-type funct to ALU control code.
module mc_aludec
    import mc_defs::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl
);
    always_comb
        alu_ctrl = funct == F_SUB ? ALU_SUB :
                   funct == F_AND ? ALU_AND :
                   funct == F_OR  ? ALU_OR  :
                   funct == F_SLT ? ALU_SLT : ALU_ADD;
endmodule

// File: rtl/mc_controlunit.sv
// mc_controlunit: multi-cycle MIPS control FSM with MULTU/DIVU stall counter.
module mc_controlunit
    import mc_defs::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       zero,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       ir_we,
    output logic       we_dm,
    output logic       we_reg,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic       alu_srca,
    output logic [1:0] alu_srcb,
    output logic [2:0] alu_ctrl,
    output logic       hilo_start,
    output logic       md_op,
    output logic       hi_en,
    output logic       lo_en,
    output logic       hilo_sel,
    output logic       illegal
);
    localparam logic [CNT_W-1:0] MUL_N = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_N = CNT_W'(DIV_CYCLES - 1);

    state_t           state, next;
    logic [CNT_W-1:0] cnt;
    logic             md_entry;
    logic             md_go;
    logic [2:0]       funct_ctrl;

    mc_aludec u_aludec (.funct(funct), .alu_ctrl(funct_ctrl));

    assign md_go = state == S_DECODE && next == S_MD_BUSY;

    // Counter is preloaded on the DECODE->MD_BUSY edge so the entry cycle already sees N-1.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= S_FETCH;
            cnt      <= '0;
            md_entry <= 1'b0;
        end else begin
            state    <= next;
            md_entry <= md_go;
            if (md_go)
                cnt <= funct == F_DIVU ? DIV_N : MUL_N;
            else if (state == S_MD_BUSY && cnt != '0)
                cnt <= cnt - 1'b1;
        end

    always_comb begin
        next       = state;
        pc_we      = 1'b0;
        pc_src     = PC_ALU;
        iord       = 1'b0;
        ir_we      = 1'b0;
        we_dm      = 1'b0;
        we_reg     = 1'b0;
        reg_dst    = RD_RT;
        wb_sel     = WB_ALU;
        alu_srca   = 1'b0;
        alu_srcb   = SRCB_RT;
        alu_ctrl   = ALU_AND;
        hilo_start = 1'b0;
        md_op      = 1'b0;
        hi_en      = 1'b0;
        lo_en      = 1'b0;
        hilo_sel   = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: begin
                ir_we    = 1'b1;
                alu_srcb = SRCB_4;
                alu_ctrl = ALU_ADD;
                pc_we    = 1'b1;
                next     = S_DECODE;
            end
            S_DECODE: begin
                alu_srcb = SRCB_IMM4;
                alu_ctrl = ALU_ADD;
                next     = S_FETCH;
                case (opcode)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_BEQ:       next = S_BRANCH;
                    OP_ADDI:      next = S_ADDI_EX;
                    OP_J:         next = S_JUMP;
                    OP_JAL:       next = S_JAL;
                    OP_RTYPE:
                        if (is_alu_funct(funct))                    next = S_RTYPE_EX;
                        else if (funct == F_MULTU || funct == F_DIVU) next = S_MD_BUSY;
                        else if (funct == F_MFHI || funct == F_MFLO)  next = S_MFHILO;
                        else if (funct == F_JR)                     next = S_JR;
                        else                                        illegal = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_srca = 1'b1;
                alu_srcb = SRCB_IMM;
                alu_ctrl = ALU_ADD;
                next     = opcode == OP_LW ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                next = S_MEMWB;
            end
            S_MEMWB: begin
                we_reg = 1'b1;
                wb_sel = WB_MDR;
                next   = S_FETCH;
            end
            S_MEMWR: begin
                iord  = 1'b1;
                we_dm = 1'b1;
                next  = S_FETCH;
            end
            S_RTYPE_EX: begin
                alu_srca = 1'b1;
                alu_ctrl = funct_ctrl;
                next     = S_ALU_WB;
            end
            S_ALU_WB: begin
                we_reg  = 1'b1;
                reg_dst = RD_RD;
                next    = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_srca = 1'b1;
                alu_srcb = SRCB_IMM;
                alu_ctrl = ALU_ADD;
                next     = S_IMM_WB;
            end
            S_IMM_WB: begin
                we_reg = 1'b1;
                next   = S_FETCH;
            end
            S_BRANCH: begin
                alu_srca = 1'b1;
                alu_ctrl = ALU_SUB;
                pc_src   = PC_BR;
                pc_we    = zero;
                next     = S_FETCH;
            end
            S_JUMP: begin
                pc_src = PC_JMP;
                pc_we  = 1'b1;
                next   = S_FETCH;
            end
            S_JAL: begin
                pc_src  = PC_JMP;
                pc_we   = 1'b1;
                we_reg  = 1'b1;
                reg_dst = RD_RA;
                wb_sel  = WB_PC;
                next    = S_FETCH;
            end
            S_JR: begin
                pc_src = PC_RS;
                pc_we  = 1'b1;
                next   = S_FETCH;
            end
            S_MD_BUSY: begin
                hilo_start = md_entry;
                md_op      = md_entry && funct == F_DIVU;
                if (cnt == '0) begin
                    hi_en = 1'b1;
                    lo_en = 1'b1;
                    next  = S_FETCH;
                end
            end
            S_MFHILO: begin
                we_reg   = 1'b1;
                reg_dst  = RD_RD;
                wb_sel   = WB_HILO;
                hilo_sel = funct == F_MFHI;
                next     = S_FETCH;
            end
        endcase
    end
endmodule

// File: tb/tb_mc_controlunit.sv
// tb_mc_controlunit: scoreboard bench checking per-instruction cycle counts and control pulses.
module tb_mc_controlunit;
    logic       clk = 1'b0;
    logic       rst, zero;
    logic [5:0] opcode, funct;
    logic       pc_we, iord, ir_we, we_dm, we_reg, alu_srca;
    logic       hilo_start, md_op, hi_en, lo_en, hilo_sel, illegal;
    logic [1:0] pc_src, reg_dst, wb_sel, alu_srcb;
    logic [2:0] alu_ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int cyc, pcwe, wereg, wedm, ill, wb, rd, hs, pcsrc, alu3;
        int nstart, start_cyc, mdop, nhw, hw_cyc;
    } rec_t;

    rec_t exp_q[$];

    mc_controlunit #(.MULT_CYCLES(1), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .zero(zero), .opcode(opcode), .funct(funct),
        .pc_we(pc_we), .pc_src(pc_src), .iord(iord), .ir_we(ir_we), .we_dm(we_dm),
        .we_reg(we_reg), .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_srca(alu_srca),
        .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl), .hilo_start(hilo_start), .md_op(md_op),
        .hi_en(hi_en), .lo_en(lo_en), .hilo_sel(hilo_sel), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic rec_t mk(input int cyc, pcwe, wereg, wedm, ill, wb, rd, hs, pcsrc, alu3,
                                input int start_cyc, mdop);
        rec_t r;
        r = '{cyc:cyc, pcwe:pcwe, wereg:wereg, wedm:wedm, ill:ill, wb:wb, rd:rd, hs:hs,
              pcsrc:pcsrc, alu3:alu3, nstart:(start_cyc != 0) ? 1 : 0, start_cyc:start_cyc,
              mdop:mdop, nhw:(start_cyc != 0) ? 1 : 0, hw_cyc:(start_cyc != 0) ? cyc : 0};
        return r;
    endfunction

    // Entered at a negedge while the DUT is in FETCH; leaves at the negedge of the next FETCH.
    task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input rec_t e);
        rec_t o, w;
        int   i;
        exp_q.push_back(e);
        opcode = op;
        funct  = fn;
        zero   = z;
        o = '{default:0};
        i = 1;
        forever begin
            if (pc_we) o.pcwe++;
            if (hilo_start) begin o.nstart++; o.start_cyc = i; o.mdop = int'(md_op); end
            if (hi_en && lo_en) begin o.nhw++; o.hw_cyc = i; end
            if (hi_en != lo_en) o.nhw += 100;
            if (we_reg) begin o.wereg++; o.wb = int'(wb_sel); o.rd = int'(reg_dst); o.hs = int'(hilo_sel); end
            if (we_dm) o.wedm++;
            if (illegal) o.ill++;
            o.pcsrc = int'(pc_src);
            if (i == 3) o.alu3 = int'(alu_ctrl);
            @(posedge clk);
            @(negedge clk);
            if (ir_we) break;
            i++;
            if (i > 100) begin
                chk({tag, ".timeout"}, i, 0);
                break;
            end
        end
        o.cyc = i;
        w = exp_q.pop_front();
        chk({tag, ".cycles"}, o.cyc, w.cyc);
        chk({tag, ".pc_we"}, o.pcwe, w.pcwe);
        chk({tag, ".we_reg"}, o.wereg, w.wereg);
        chk({tag, ".we_dm"}, o.wedm, w.wedm);
        chk({tag, ".illegal"}, o.ill, w.ill);
        chk({tag, ".wb_sel"}, o.wb, w.wb);
        chk({tag, ".reg_dst"}, o.rd, w.rd);
        chk({tag, ".hilo_sel"}, o.hs, w.hs);
        chk({tag, ".pc_src"}, o.pcsrc, w.pcsrc);
        chk({tag, ".alu_ctrl3"}, o.alu3, w.alu3);
        chk({tag, ".n_start"}, o.nstart, w.nstart);
        chk({tag, ".start_cyc"}, o.start_cyc, w.start_cyc);
        chk({tag, ".md_op"}, o.mdop, w.mdop);
        chk({tag, ".n_hilo_we"}, o.nhw, w.nhw);
        chk({tag, ".hilo_we_cyc"}, o.hw_cyc, w.hw_cyc);
    endtask

    initial begin
        int hw_seen;
        rst = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
        repeat (2) @(negedge clk);
        chk("rst.ir_we", int'(ir_we), 1);
        chk("rst.pc_we", int'(pc_we), 1);
        chk("rst.alu_srcb", int'(alu_srcb), 1);
        chk("rst.alu_ctrl", int'(alu_ctrl), 2);
        chk("rst.iord", int'(iord), 0);
        rst = 1'b0;
        //                                    cyc pcwe wreg wdm ill wb rd hs pcs alu3 st md
        run("lw",    6'b100011, 6'h00, 0, mk(5, 1, 1, 0, 0, 1, 0, 0, 0, 2, 0, 0));
        run("sw",    6'b101011, 6'h00, 0, mk(4, 1, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0));
        run("add",   6'b000000, 6'b100000, 0, mk(4, 1, 1, 0, 0, 0, 1, 0, 0, 2, 0, 0));
        run("sub",   6'b000000, 6'b100010, 0, mk(4, 1, 1, 0, 0, 0, 1, 0, 0, 6, 0, 0));
        run("and",   6'b000000, 6'b100100, 0, mk(4, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        run("or",    6'b000000, 6'b100101, 0, mk(4, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        run("slt",   6'b000000, 6'b101010, 0, mk(4, 1, 1, 0, 0, 0, 1, 0, 0, 7, 0, 0));
        run("addi",  6'b001000, 6'h00, 0, mk(4, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        run("beq_t", 6'b000100, 6'h00, 1, mk(3, 2, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0));
        run("beq_n", 6'b000100, 6'h00, 0, mk(3, 1, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0));
        run("j",     6'b000010, 6'h00, 0, mk(3, 2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
        run("jal",   6'b000011, 6'h00, 0, mk(3, 2, 1, 0, 0, 2, 2, 0, 2, 0, 0, 0));
        run("jr",    6'b000000, 6'b001000, 0, mk(3, 2, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
        run("mfhi",  6'b000000, 6'b010000, 0, mk(3, 1, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0));
        run("mflo",  6'b000000, 6'b010010, 0, mk(3, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0));
        run("multu", 6'b000000, 6'b011001, 0, mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        run("divu",  6'b000000, 6'b011011, 0, mk(34, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1));
        run("ill_op", 6'b111111, 6'h00, 0, mk(2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        run("ill_fn", 6'b000000, 6'b000001, 0, mk(2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        // Abort a DIVU partway through with an asynchronous reset.
        opcode = 6'b000000; funct = 6'b011011;
        hw_seen = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (hi_en || lo_en) hw_seen++;
        end
        chk("abort.busy", int'(ir_we), 0);
        rst = 1'b1;
        #1;
        chk("abort.ir_we", int'(ir_we), 1);
        chk("abort.hi_en", int'(hi_en), 0);
        chk("abort.hw_seen", hw_seen, 0);
        @(negedge clk);
        rst = 1'b0;
        run("lw2",   6'b100011, 6'h00, 0, mk(5, 1, 1, 0, 0, 1, 0, 0, 0, 2, 0, 0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
